// File: rtl/atomrvcore_decode_stage.sv
// RV32I/RV32E decode stage: decoder, register file with write-back bypass,
// load-use scoreboard and a valid/ready output register with flush.
module atomrvcore_decode_stage #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        instr_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               wb_en_i,
    input  logic [RADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]    wb_data_i,
    input  logic               wb_load_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    out_pc_o,
    output logic [XLEN-1:0]    out_opa_o,
    output logic [XLEN-1:0]    out_opb_o,
    output logic [XLEN-1:0]    out_rs2_o,
    output logic [XLEN-1:0]    out_imm_o,
    output logic [RADDR_W-1:0] out_rd_o,
    output logic               out_rwr_en_o,
    output logic [ALUOP_W-1:0] out_aluop_o,
    output logic [5:0]         out_type_o,
    output logic               out_load_o,
    output logic               out_store_o,
    output logic               out_jalr_o,
    output logic               out_illegal_o
);

    localparam int IDX_W = (RADDR_W > 5) ? RADDR_W : 5;
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [ALUOP_W-1:0] OP_PASS = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] OP_BEQ  = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] OP_BNE  = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] OP_BLT  = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] OP_BGE  = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] OP_BLTU = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] OP_BGEU = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] OP_JAL  = ALUOP_W'(17);

    localparam logic [5:0] T_I  = 6'b000001;
    localparam logic [5:0] T_R  = 6'b000010;
    localparam logic [5:0] T_S  = 6'b000100;
    localparam logic [5:0] T_SB = 6'b001000;
    localparam logic [5:0] T_U  = 6'b010000;
    localparam logic [5:0] T_UJ = 6'b100000;

    typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_e;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return int'(idx) < NREGS;
    endfunction

    // Shared funct3 mapping of OP and OP-IMM when funct7 is zero
    function automatic logic [ALUOP_W-1:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [IDX_W-1:0] rs1_idx, rs2_idx, rd_idx, wb_idx;

    assign opcode  = instr_i[6:0];
    assign f3      = instr_i[14:12];
    assign f7      = instr_i[31:25];
    assign rs1_idx = IDX_W'(instr_i[19:15]);
    assign rs2_idx = IDX_W'(instr_i[24:20]);
    assign rd_idx  = IDX_W'(instr_i[11:7]);
    assign wb_idx  = IDX_W'(wb_rd_i);

    logic [XLEN-1:0]  rf [NREGS];
    logic [NREGS-1:0] pend, pend_n;
    logic             wb_wr, wb_clr;

    assign wb_wr  = wb_en_i && (wb_idx != '0) && idx_ok(wb_idx);
    assign wb_clr = wb_en_i && wb_load_i && idx_ok(wb_idx);

    // Operand read with write-first bypass from the write-back port
    logic [XLEN-1:0] rs1_val, rs2_val;
    always_comb begin
        if (rs1_idx == '0 || !idx_ok(rs1_idx))
            rs1_val = '0;
        else if (wb_wr && wb_idx == rs1_idx)
            rs1_val = wb_data_i;
        else
            rs1_val = rf[rs1_idx[AW-1:0]];
        if (rs2_idx == '0 || !idx_ok(rs2_idx))
            rs2_val = '0;
        else if (wb_wr && wb_idx == rs2_idx)
            rs2_val = wb_data_i;
        else
            rs2_val = rf[rs2_idx[AW-1:0]];
    end

    logic [ALUOP_W-1:0] dec_aluop;
    logic [5:0]         dec_type;
    logic               dec_load, dec_store, dec_jalr, dec_wr;
    logic               use_rs1, use_rs2, bad_enc;
    opa_sel_e           opa_sel;

    always_comb begin
        dec_aluop = OP_PASS;
        dec_type  = '0;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        dec_jalr  = 1'b0;
        dec_wr    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        bad_enc   = 1'b0;
        opa_sel   = OPA_RS1;
        case (opcode)
            7'b0110111: begin
                dec_type = T_U; dec_aluop = OP_ADD; dec_wr = 1'b1; opa_sel = OPA_ZERO;
            end
            7'b0010111: begin
                dec_type = T_U; dec_aluop = OP_ADD; dec_wr = 1'b1; opa_sel = OPA_PC;
            end
            7'b1101111: begin
                dec_type = T_UJ; dec_aluop = OP_JAL; dec_wr = 1'b1; opa_sel = OPA_PC;
            end
            7'b1100111: begin
                dec_type = T_I; dec_aluop = OP_ADD; dec_wr = 1'b1; use_rs1 = 1'b1;
                dec_jalr = (f3 == 3'b000);
                bad_enc  = (f3 != 3'b000);
            end
            7'b1100011: begin
                dec_type = T_SB; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3)
                    3'b000:  dec_aluop = OP_BEQ;
                    3'b001:  dec_aluop = OP_BNE;
                    3'b100:  dec_aluop = OP_BLT;
                    3'b101:  dec_aluop = OP_BGE;
                    3'b110:  dec_aluop = OP_BLTU;
                    3'b111:  dec_aluop = OP_BGEU;
                    default: bad_enc = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec_type = T_I; dec_aluop = OP_ADD; dec_load = 1'b1; dec_wr = 1'b1;
                use_rs1  = 1'b1;
                bad_enc  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            7'b0100011: begin
                dec_type = T_S; dec_aluop = OP_ADD; dec_store = 1'b1;
                use_rs1  = 1'b1; use_rs2 = 1'b1;
                bad_enc  = (f3 > 3'b010);
            end
            7'b0010011: begin
                dec_type = T_I; dec_wr = 1'b1; use_rs1 = 1'b1;
                dec_aluop = base_op(f3);
                if (f3 == 3'b001)
                    bad_enc = (f7 != 7'b0000000);
                else if (f3 == 3'b101) begin
                    if (f7 == 7'b0100000)
                        dec_aluop = OP_SRA;
                    else if (f7 != 7'b0000000)
                        bad_enc = 1'b1;
                end
            end
            7'b0110011: begin
                dec_type = T_R; dec_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (f7 == 7'b0000000)
                    dec_aluop = base_op(f3);
                else if (f7 == 7'b0100000 && f3 == 3'b000)
                    dec_aluop = OP_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101)
                    dec_aluop = OP_SRA;
                else
                    bad_enc = 1'b1;
            end
            default: bad_enc = 1'b1;
        endcase
    end

    logic signed [31:0] imm32;
    always_comb begin
        case (dec_type)
            T_I:     imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            T_S:     imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            T_SB:    imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            T_U:     imm32 = {instr_i[31:12], 12'b0};
            T_UJ:    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    logic [XLEN-1:0] dec_imm, dec_opa, dec_opb;
    logic            dec_illegal, dec_rwr, dec_load_ok, dec_store_ok;

    assign dec_imm      = XLEN'(imm32);
    assign dec_illegal  = bad_enc || (use_rs1 && !idx_ok(rs1_idx)) ||
                          (use_rs2 && !idx_ok(rs2_idx)) || (dec_wr && !idx_ok(rd_idx));
    assign dec_rwr      = dec_wr && (rd_idx != '0) && !dec_illegal;
    assign dec_load_ok  = dec_load && !dec_illegal;
    assign dec_store_ok = dec_store && !dec_illegal;
    assign dec_opb      = (dec_type == T_R || dec_type == T_SB) ? rs2_val : dec_imm;

    always_comb begin
        case (opa_sel)
            OPA_PC:   dec_opa = pc_i;
            OPA_ZERO: dec_opa = '0;
            default:  dec_opa = rs1_val;
        endcase
    end

    // A write-back that clears a pending bit this cycle also bypasses its data
    logic rs1_pend, rs2_pend, hazard, accept, sb_set;
    always_comb begin
        rs1_pend = idx_ok(rs1_idx) ? pend[rs1_idx[AW-1:0]] : 1'b0;
        rs2_pend = idx_ok(rs2_idx) ? pend[rs2_idx[AW-1:0]] : 1'b0;
        hazard   = (use_rs1 && rs1_pend && !(wb_clr && wb_idx == rs1_idx)) ||
                   (use_rs2 && rs2_pend && !(wb_clr && wb_idx == rs2_idx));
    end

    logic               vld_p1, rwr_p1, load_p1, store_p1, jalr_p1, illegal_p1;
    logic [XLEN-1:0]    pc_p1, opa_p1, opb_p1, rs2_p1, imm_p1;
    logic [RADDR_W-1:0] rd_p1;
    logic [ALUOP_W-1:0] aluop_p1;
    logic [5:0]         type_p1;

    assign in_ready_o = rst_ni && !flush_i && !hazard && (!vld_p1 || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign sb_set     = accept && dec_load_ok && (rd_idx != '0);

    // Set beats clear when both hit the same register in one cycle
    always_comb begin
        pend_n = pend;
        if (wb_clr)
            pend_n[wb_idx[AW-1:0]] = 1'b0;
        if (flush_i && vld_p1 && load_p1)
            pend_n[rd_p1[AW-1:0]] = 1'b0;
        if (sb_set)
            pend_n[rd_idx[AW-1:0]] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend <= '0;
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else begin
            pend <= pend_n;
            if (wb_wr)
                rf[wb_idx[AW-1:0]] <= wb_data_i;
        end
    end

    // Stage p1: decoded bundle, held while execute back-pressures
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            opa_p1     <= '0;
            opb_p1     <= '0;
            rs2_p1     <= '0;
            imm_p1     <= '0;
            rd_p1      <= '0;
            rwr_p1     <= 1'b0;
            aluop_p1   <= '0;
            type_p1    <= '0;
            load_p1    <= 1'b0;
            store_p1   <= 1'b0;
            jalr_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1     <= 1'b1;
            pc_p1      <= pc_i;
            opa_p1     <= dec_opa;
            opb_p1     <= dec_opb;
            rs2_p1     <= rs2_val;
            imm_p1     <= dec_imm;
            rd_p1      <= RADDR_W'(instr_i[11:7]);
            rwr_p1     <= dec_rwr;
            aluop_p1   <= dec_aluop;
            type_p1    <= dec_type;
            load_p1    <= dec_load_ok;
            store_p1   <= dec_store_ok;
            jalr_p1    <= dec_jalr;
            illegal_p1 <= dec_illegal;
        end else if (flush_i || out_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid_o   = vld_p1;
    assign out_pc_o      = pc_p1;
    assign out_opa_o     = opa_p1;
    assign out_opb_o     = opb_p1;
    assign out_rs2_o     = rs2_p1;
    assign out_imm_o     = imm_p1;
    assign out_rd_o      = rd_p1;
    assign out_rwr_en_o  = rwr_p1;
    assign out_aluop_o   = aluop_p1;
    assign out_type_o    = type_p1;
    assign out_load_o    = load_p1;
    assign out_store_o   = store_p1;
    assign out_jalr_o    = jalr_p1;
    assign out_illegal_o = illegal_p1;

endmodule

// File: tb/tb_atomrvcore_decode_stage.sv
// Directed bench for atomrvcore_decode_stage: an RV32I instance plus an RV32E
// instance fed the same stimulus.
module tb_atomrvcore_decode_stage;

    logic        clk = 1'b0;
    logic        rst_ni, flush_i, in_valid_i, out_ready_i;
    logic        wb_en_i, wb_load_i;
    logic [31:0] instr_i, pc_i, wb_data_i;
    logic [4:0]  wb_rd_i;

    logic        in_ready, out_valid, out_rwr, out_load, out_store, out_jalr, out_ill;
    logic [31:0] out_pc, out_opa, out_opb, out_rs2, out_imm;
    logic [4:0]  out_rd;
    logic [5:0]  out_aluop, out_type;

    logic        e_in_ready, e_out_valid, e_out_rwr, e_out_load, e_out_store, e_out_jalr, e_out_ill;
    logic [31:0] e_out_pc, e_out_opa, e_out_opb, e_out_rs2, e_out_imm;
    logic [4:0]  e_out_rd;
    logic [5:0]  e_out_aluop, e_out_type;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    atomrvcore_decode_stage #(.XLEN(32), .NREGS(32), .RADDR_W(5), .ALUOP_W(6)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready), .instr_i(instr_i), .pc_i(pc_i), .wb_en_i(wb_en_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_load_i(wb_load_i),
        .out_valid_o(out_valid), .out_ready_i(out_ready_i), .out_pc_o(out_pc),
        .out_opa_o(out_opa), .out_opb_o(out_opb), .out_rs2_o(out_rs2), .out_imm_o(out_imm),
        .out_rd_o(out_rd), .out_rwr_en_o(out_rwr), .out_aluop_o(out_aluop),
        .out_type_o(out_type), .out_load_o(out_load), .out_store_o(out_store),
        .out_jalr_o(out_jalr), .out_illegal_o(out_ill)
    );

    atomrvcore_decode_stage #(.XLEN(32), .NREGS(16), .RADDR_W(5), .ALUOP_W(6)) u_dut_e (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(e_in_ready), .instr_i(instr_i), .pc_i(pc_i), .wb_en_i(wb_en_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_load_i(wb_load_i),
        .out_valid_o(e_out_valid), .out_ready_i(out_ready_i), .out_pc_o(e_out_pc),
        .out_opa_o(e_out_opa), .out_opb_o(e_out_opb), .out_rs2_o(e_out_rs2),
        .out_imm_o(e_out_imm), .out_rd_o(e_out_rd), .out_rwr_en_o(e_out_rwr),
        .out_aluop_o(e_out_aluop), .out_type_o(e_out_type), .out_load_o(e_out_load),
        .out_store_o(e_out_store), .out_jalr_o(e_out_jalr), .out_illegal_o(e_out_ill)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid_i = 1'b1; instr_i = ins; pc_i = pc;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_cmp++; if ({out_pc, out_opa, out_imm} !== 96'h0) begin n_bad++; $display("FAIL reset_data got %h exp 0", {out_pc, out_opa, out_imm}); end
        n_cmp++; if ({out_rd, out_aluop, out_type, out_rwr} !== 18'h0) begin n_bad++; $display("FAIL reset_ctrl got %h exp 0", {out_rd, out_aluop, out_type, out_rwr}); end
        rst_ni = 1'b1;
    endtask

    task automatic test_addi();
        in_valid_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h100;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL addi_in_ready got %b exp 1", in_ready); end
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid got %b exp 1", out_valid); end
        n_cmp++; if (out_opa !== 32'h0 || out_opb !== 32'h5) begin n_bad++; $display("FAIL addi_ops got %h/%h exp 0/5", out_opa, out_opb); end
        n_cmp++; if (out_rd !== 5'd1 || out_rwr !== 1'b1) begin n_bad++; $display("FAIL addi_rd got %0d/%b exp 1/1", out_rd, out_rwr); end
        n_cmp++; if (out_aluop !== 6'd1 || out_type !== 6'b000001) begin n_bad++; $display("FAIL addi_op got %0d/%b exp 1/000001", out_aluop, out_type); end
        n_cmp++; if (out_pc !== 32'h100 || out_ill !== 1'b0) begin n_bad++; $display("FAIL addi_pc got %h/%b exp 100/0", out_pc, out_ill); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL addi_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_regfile_bypass();
        wb_en_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h3;
        tick();
        wb_rd_i = 5'd2; wb_data_i = 32'h7;
        issue(32'h002081B3, 32'h110);
        wb_en_i = 1'b0;
        n_cmp++; if (out_opa !== 32'h3 || out_opb !== 32'h7) begin n_bad++; $display("FAIL bypass_ops got %h/%h exp 3/7", out_opa, out_opb); end
        n_cmp++; if (out_aluop !== 6'd1 || out_type !== 6'b000010 || out_rd !== 5'd3) begin n_bad++; $display("FAIL bypass_dec got %0d/%b/%0d exp 1/000010/3", out_aluop, out_type, out_rd); end
        issue(32'h002081B3, 32'h114);
        n_cmp++; if (out_opb !== 32'h7) begin n_bad++; $display("FAIL rf_write got %h exp 7", out_opb); end
        wb_en_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hDEAD;
        issue(32'h000001B3, 32'h118);
        wb_en_i = 1'b0;
        n_cmp++; if (out_opa !== 32'h0 || out_opb !== 32'h0) begin n_bad++; $display("FAIL x0_zero got %h/%h exp 0/0", out_opa, out_opb); end
    endtask

    task automatic test_decode();
        issue(32'h40208233, 32'h120);
        n_cmp++; if (out_aluop !== 6'd10 || out_opa !== 32'h3 || out_opb !== 32'h7) begin n_bad++; $display("FAIL sub got %0d/%h/%h exp 10/3/7", out_aluop, out_opa, out_opb); end
        issue(32'h123453B7, 32'h124);
        n_cmp++; if (out_opa !== 32'h0 || out_opb !== 32'h12345000 || out_type !== 6'b010000 || out_aluop !== 6'd1) begin n_bad++; $display("FAIL lui got %h/%h/%b/%0d exp 0/12345000/010000/1", out_opa, out_opb, out_type, out_aluop); end
        issue(32'hFFFFF417, 32'h404);
        n_cmp++; if (out_opa !== 32'h404 || out_imm !== 32'hFFFFF000 || out_rd !== 5'd8) begin n_bad++; $display("FAIL auipc got %h/%h/%0d exp 404/fffff000/8", out_opa, out_imm, out_rd); end
        issue(32'hFE20AE23, 32'h128);
        n_cmp++; if (out_imm !== 32'hFFFFFFFC || out_opb !== 32'hFFFFFFFC || out_opa !== 32'h3 || out_rs2 !== 32'h7) begin n_bad++; $display("FAIL sw_ops got %h/%h/%h/%h exp fffffffc/fffffffc/3/7", out_imm, out_opb, out_opa, out_rs2); end
        n_cmp++; if (out_store !== 1'b1 || out_rwr !== 1'b0 || out_type !== 6'b000100 || out_load !== 1'b0) begin n_bad++; $display("FAIL sw_flags got %b/%b/%b/%b exp 1/0/000100/0", out_store, out_rwr, out_type, out_load); end
        issue(32'hFE208CE3, 32'h12C);
        n_cmp++; if (out_imm !== 32'hFFFFFFF8 || out_aluop !== 6'd11 || out_type !== 6'b001000 || out_opb !== 32'h7 || out_rwr !== 1'b0) begin n_bad++; $display("FAIL beq got %h/%0d/%b/%h/%b exp fffffff8/11/001000/7/0", out_imm, out_aluop, out_type, out_opb, out_rwr); end
        issue(32'h001000EF, 32'h400);
        n_cmp++; if (out_imm !== 32'h800 || out_aluop !== 6'd17 || out_type !== 6'b100000 || out_opa !== 32'h400 || out_rwr !== 1'b1) begin n_bad++; $display("FAIL jal got %h/%0d/%b/%h/%b exp 800/17/100000/400/1", out_imm, out_aluop, out_type, out_opa, out_rwr); end
        issue(32'h4030D493, 32'h130);
        n_cmp++; if (out_aluop !== 6'd7 || out_opb !== 32'h403 || out_opa !== 32'h3) begin n_bad++; $display("FAIL srai got %0d/%h/%h exp 7/403/3", out_aluop, out_opb, out_opa); end
        issue(32'hFFF00513, 32'h134);
        n_cmp++; if (out_opb !== 32'hFFFFFFFF || out_rd !== 5'd10) begin n_bad++; $display("FAIL addi_neg got %h/%0d exp ffffffff/10", out_opb, out_rd); end
        issue(32'h00000000, 32'h138);
        n_cmp++; if (out_valid !== 1'b1 || out_ill !== 1'b1 || out_rwr !== 1'b0) begin n_bad++; $display("FAIL illegal_op got %b/%b/%b exp 1/1/0", out_valid, out_ill, out_rwr); end
        tick();
    endtask

    task automatic test_load_use();
        issue(32'h0000A283, 32'h140);
        n_cmp++; if (out_load !== 1'b1 || out_opb !== 32'h0 || out_opa !== 32'h3) begin n_bad++; $display("FAIL lw_dec got %b/%h/%h exp 1/0/3", out_load, out_opb, out_opa); end
        in_valid_i = 1'b1; instr_i = 32'h00528333; pc_i = 32'h144;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL lu_stall%0d got %b exp 0", i, in_ready); end
            tick();
        end
        wb_en_i = 1'b1; wb_load_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h1234;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lu_release got %b exp 1", in_ready); end
        tick();
        in_valid_i = 1'b0; wb_en_i = 1'b0; wb_load_i = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_opa !== 32'h1234 || out_opb !== 32'h1234 || out_rd !== 5'd6 || out_pc !== 32'h144) begin n_bad++; $display("FAIL lu_bundle got %b/%h/%h/%0d/%h exp 1/1234/1234/6/144", out_valid, out_opa, out_opb, out_rd, out_pc); end
        in_valid_i = 1'b1; instr_i = 32'h00528333; pc_i = 32'h148;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lu_cleared got %b exp 1", in_ready); end
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_opa !== 32'h1234) begin n_bad++; $display("FAIL lu_rf got %h exp 1234", out_opa); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h200;
        tick();
        instr_i = 32'h00B00593; pc_i = 32'h204;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_opb !== 32'h5 || out_rd !== 5'd1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL hold%0d got %b/%h/%h/%0d/%b exp 1/200/5/1/0", i, out_valid, out_pc, out_opb, out_rd, in_ready); end
            tick();
        end
        n_cmp++; if (out_pc !== 32'h200 || out_aluop !== 6'd1) begin n_bad++; $display("FAIL hold_end got %h/%0d exp 200/1", out_pc, out_aluop); end
        out_ready_i = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready got %b exp 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_rd !== 5'd11 || out_opb !== 32'hB) begin n_bad++; $display("FAIL b2b_first got %b/%h/%0d/%h exp 1/204/11/b", out_valid, out_pc, out_rd, out_opb); end
        instr_i = 32'h00C00613; pc_i = 32'h208;
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h208 || out_rd !== 5'd12) begin n_bad++; $display("FAIL b2b_second got %b/%h/%0d exp 1/208/12", out_valid, out_pc, out_rd); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        issue(32'h0000A283, 32'h300);
        n_cmp++; if (out_valid !== 1'b1 || out_load !== 1'b1) begin n_bad++; $display("FAIL fl_load got %b/%b exp 1/1", out_valid, out_load); end
        in_valid_i = 1'b1; instr_i = 32'h00528333; pc_i = 32'h304; flush_i = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_no_accept got %b exp 0", in_ready); end
        tick();
        flush_i = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_killed got %b exp 0", out_valid); end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fl_pend_clear got %b exp 1", in_ready); end
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_opa !== 32'h1234 || out_pc !== 32'h304) begin n_bad++; $display("FAIL fl_next got %b/%0d/%h/%h exp 1/6/1234/304", out_valid, out_rd, out_opa, out_pc); end
        out_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_rv32e_and_reset();
        issue(32'h00100A13, 32'h400);
        n_cmp++; if (e_out_valid !== 1'b1 || e_out_ill !== 1'b1 || e_out_rwr !== 1'b0) begin n_bad++; $display("FAIL e_illegal got %b/%b/%b exp 1/1/0", e_out_valid, e_out_ill, e_out_rwr); end
        n_cmp++; if (out_ill !== 1'b0 || out_rwr !== 1'b1 || out_rd !== 5'd20) begin n_bad++; $display("FAIL i_x20 got %b/%b/%0d exp 0/1/20", out_ill, out_rwr, out_rd); end
        issue(32'h0000A283, 32'h404);
        rst_ni = 1'b0;
        in_valid_i = 1'b1; instr_i = 32'h00528333; pc_i = 32'h408;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b exp 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin n_bad++; $display("FAIL rst_mid got %b/%h exp 0/0", out_valid, out_pc); end
        rst_ni = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_sb_clear got %b exp 1", in_ready); end
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_opa !== 32'h0) begin n_bad++; $display("FAIL rst_x5 got %b/%h exp 1/0", out_valid, out_opa); end
        issue(32'h002081B3, 32'h40C);
        n_cmp++; if (out_opa !== 32'h0 || out_opb !== 32'h0) begin n_bad++; $display("FAIL rst_rf got %h/%h exp 0/0", out_opa, out_opb); end
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        instr_i = '0; pc_i = '0; wb_en_i = 1'b0; wb_load_i = 1'b0;
        wb_rd_i = '0; wb_data_i = '0;
        test_reset();
        test_addi();
        test_regfile_bypass();
        test_decode();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_rv32e_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
